// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I decode stage (OP-IMM, OP, LUI, AUIPC).
//                Reads both source registers, builds the immediate and
//                presents ALU op code plus operands in a valid/ready
//                pipeline register that feeds the ALU directly.
//  Ports       : clk, reset (sync, active-high), flush
//                in_valid/in_ready, instr, pc       - fetch side
//                rs1_addr/rs2_addr, rs1_data/rs2_data - register file
//                out_valid/out_ready, alu_op, alu_a, alu_b, rd, rd_we,
//                illegal                             - execute side
//                dec_count                           - accepted-instr count
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal,
  output logic [31:0] dec_count
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;

  logic [5:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_ill;
  logic        accept;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // x0 always reads as zero whatever the register file returns
  assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
  assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Reset also blocks acceptance so nothing is loaded under reset
  assign in_ready = !reset && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_op  = 6'd0;
    dec_a   = 32'd0;
    dec_b   = 32'd0;
    dec_ill = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: begin
        dec_a = rs1_val;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_op = 6'd0;
          3'b010: dec_op = 6'd1;
          3'b011: dec_op = 6'd2;
          3'b100: dec_op = 6'd3;
          3'b110: dec_op = 6'd4;
          3'b111: dec_op = 6'd5;
          3'b001: begin
            dec_b = imm_sh;
            if (funct7 == F7_ZERO) dec_op = 6'd6;
            else                   dec_ill = 1'b1;
          end
          default: begin  // 3'b101
            dec_b = imm_sh;
            if      (funct7 == F7_ZERO) dec_op = 6'd7;
            else if (funct7 == F7_ALT)  dec_op = 6'd8;
            else                        dec_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  dec_op = 6'd9;
            3'b001:  dec_op = 6'd11;
            3'b010:  dec_op = 6'd12;
            3'b011:  dec_op = 6'd13;
            3'b100:  dec_op = 6'd14;
            3'b101:  dec_op = 6'd15;
            3'b110:  dec_op = 6'd17;
            default: dec_op = 6'd18;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = 6'd10;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = 6'd16;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_a = 32'd0;
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase

    // Illegal bundles carry no operand information downstream
    if (dec_ill) begin
      dec_op = 6'd0;
      dec_a  = 32'd0;
      dec_b  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_op    <= 6'd0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      rd        <= 5'd0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
      dec_count <= 32'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_op    <= dec_op;
      alu_a     <= dec_a;
      alu_b     <= dec_b;
      rd        <= instr[11:7];
      rd_we     <= !dec_ill && (instr[11:7] != 5'd0);
      illegal   <= dec_ill;
      dec_count <= dec_count + 32'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
